// File: rtl/fb_read_arbiter.sv
// rtl/fb_read_arbiter.sv - frame buffer read-port arbiter, video priority with CPU starvation override
module fb_read_arbiter #(
    parameter int AW       = 17,
    parameter int DW       = 12,
    parameter int FB_WORDS = 19200,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_data,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_t;

    localparam logic [3:0]    WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [AW-1:0] FB_LIMIT = AW'(FB_WORDS);

    gnt_t          winner;
    gnt_t          gnt_q;
    logic [3:0]    wait_cnt;
    logic          oor_q;
    logic [AW-1:0] win_addr;
    logic          in_range;
    logic [DW-1:0] ret_data;
    logic [DW-1:0] vid_hold;
    logic [DW-1:0] cpu_hold;

    // Pick this cycle's winner: CPU only when video is idle or the CPU has waited long enough
    always_comb begin
        winner = GNT_NONE;
        if (!rst) begin
            if (cpu_req && (!vid_req || wait_cnt == WAIT_MAX)) begin
                winner = GNT_CPU;
            end else if (vid_req) begin
                winner = GNT_VID;
            end
        end
    end

    // Drive the RAM port and acks from the winner; out-of-range reads are acked but not issued
    always_comb begin
        win_addr = '0;
        case (winner)
            GNT_VID: win_addr = vid_addr;
            GNT_CPU: win_addr = cpu_addr;
            default: win_addr = '0;
        endcase
        in_range  = (win_addr < FB_LIMIT);
        vid_ack   = (winner == GNT_VID);
        cpu_ack   = (winner == GNT_CPU);
        mem_addr  = win_addr;
        mem_rd_en = (winner != GNT_NONE) && in_range;
    end

    // Return path: steer last cycle's RAM data to its owner, otherwise show the held value
    always_comb begin
        ret_data  = oor_q ? '0 : mem_data;
        vid_valid = !rst && (gnt_q == GNT_VID);
        cpu_valid = !rst && (gnt_q == GNT_CPU);
        vid_data  = vid_valid ? ret_data : vid_hold;
        cpu_data  = cpu_valid ? ret_data : cpu_hold;
    end

    // Grant tag pipeline, starvation counter, held return data and conflict statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q        <= GNT_NONE;
            oor_q        <= 1'b0;
            wait_cnt     <= '0;
            vid_hold     <= '0;
            cpu_hold     <= '0;
            conflict_cnt <= '0;
        end else begin
            gnt_q <= winner;
            oor_q <= (winner != GNT_NONE) && !in_range;

            if (!cpu_req || cpu_ack) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (vid_valid) begin
                vid_hold <= ret_data;
            end
            if (cpu_valid) begin
                cpu_hold <= ret_data;
            end

            if (vid_req && cpu_req && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// tb/tb_fb_read_arbiter.sv - randomized and directed bench for fb_read_arbiter
module tb_fb_read_arbiter;

    localparam int AW       = 17;
    localparam int DW       = 12;
    localparam int FB_WORDS = 19200;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ack;
    logic          cpu_valid;
    logic [DW-1:0] cpu_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [15:0]   conflict_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    fb_read_arbiter #(
        .AW(AW), .DW(DW), .FB_WORDS(FB_WORDS), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Frame buffer RAM: each word holds the low 12 bits of its own address
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem_addr[11:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return AW'(FB_WORDS + $urandom_range(0, 300));
        if (r == 1) return AW'(FB_WORDS - 1);
        return AW'($urandom_range(0, FB_WORDS - 1));
    endfunction

    // Reference model state: pending return per requester, last delivered values
    int            m_wait = 0;
    int            m_conf = 0;
    bit            m_pv   = 0;
    bit            m_pc   = 0;
    logic [DW-1:0] m_pdata = '0;
    logic [DW-1:0] m_vhold = '0;
    logic [DW-1:0] m_chold = '0;

    // Compare every output against the model mid-cycle, then advance the model to the next cycle
    always @(negedge clk) begin
        bit            cw, vw, e_rd, e_vv, e_cv;
        logic [AW-1:0] waddr;
        cw    = !rst && cpu_req && (!vid_req || m_wait >= MAX_WAIT);
        vw    = !rst && vid_req && !cw;
        waddr = cw ? cpu_addr : (vw ? vid_addr : '0);
        e_rd  = (cw || vw) && (int'(waddr) < FB_WORDS);
        e_vv  = !rst && m_pv;
        e_cv  = !rst && m_pc;
        if (chk_en) begin
            chk("vid_ack",   32'(vid_ack),   32'(vw));
            chk("cpu_ack",   32'(cpu_ack),   32'(cw));
            chk("mem_addr",  32'(mem_addr),  32'(waddr));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
            chk("vid_valid", 32'(vid_valid), 32'(e_vv));
            chk("cpu_valid", 32'(cpu_valid), 32'(e_cv));
            chk("vid_data",  32'(vid_data),  32'(e_vv ? m_pdata : m_vhold));
            chk("cpu_data",  32'(cpu_data),  32'(e_cv ? m_pdata : m_chold));
            chk("conflict",  32'(conflict_cnt), 32'(m_conf));
        end
        if (rst) begin
            m_wait = 0; m_conf = 0; m_pv = 0; m_pc = 0;
            m_pdata = '0; m_vhold = '0; m_chold = '0;
        end else begin
            if (m_pv) m_vhold = m_pdata;
            if (m_pc) m_chold = m_pdata;
            m_pdata = (int'(waddr) < FB_WORDS) ? waddr[11:0] : '0;
            m_pv = vw;
            m_pc = cw;
            if (!cpu_req || cw) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            if (vid_req && cpu_req && m_conf < 65535) m_conf++;
        end
    end

    initial begin
        bit va, ca;
        int ngrant;

        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_vid_valid", 32'(vid_valid), 0);
        chk("rst_cpu_valid", 32'(cpu_valid), 0);
        chk("rst_conflict",  32'(conflict_cnt), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_vid_data",  32'(vid_data), 0);
        cyc(); rst = 1'b0;

        // Video streams addresses 0,1,2 back to back
        cyc(); vid_req = 1; vid_addr = 0;
        @(negedge clk); chk("v0_ack", 32'(vid_ack), 1);
        cyc(); vid_addr = 1;
        @(negedge clk); chk("v0_valid", 32'(vid_valid), 1); chk("v0_data", 32'(vid_data), 32'h000);
        cyc(); vid_addr = 2;
        @(negedge clk); chk("v1_data", 32'(vid_data), 32'h001); chk("v1_ack", 32'(vid_ack), 1);
        cyc(); vid_req = 0;
        @(negedge clk); chk("v2_data", 32'(vid_data), 32'h002); chk("v_cpu_valid", 32'(cpu_valid), 0);

        // CPU reads the last valid word
        cyc(); cpu_req = 1; cpu_addr = 17'd19199;
        @(negedge clk); chk("c_last_ack", 32'(cpu_ack), 1); chk("c_last_rd", 32'(mem_rd_en), 1);
        cyc(); cpu_req = 0;
        @(negedge clk); chk("c_last_valid", 32'(cpu_valid), 1); chk("c_last_data", 32'(cpu_data), 32'hAFF);
        chk("c_last_rd_off", 32'(mem_rd_en), 0);

        // Starvation override: CPU refused four times, granted on the fifth
        cyc(); vid_req = 1; vid_addr = 10; cpu_req = 1; cpu_addr = 5;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk); chk("starve_cpu_ack", 32'(cpu_ack), 0); chk("starve_vid_ack", 32'(vid_ack), 1);
            cyc();
        end
        @(negedge clk); chk("ovr_cpu_ack", 32'(cpu_ack), 1); chk("ovr_vid_ack", 32'(vid_ack), 0);
        chk("ovr_addr", 32'(mem_addr), 5);
        cyc(); cpu_req = 0;
        @(negedge clk); chk("ovr_cpu_data", 32'(cpu_data), 5); chk("ovr_vid_resume", 32'(vid_ack), 1);
        chk("ovr_conflict", 32'(conflict_cnt), 5);
        cyc(); vid_req = 0;

        // Out-of-range CPU read returns zero without touching RAM
        cyc(); cpu_req = 1; cpu_addr = 17'd19200;
        @(negedge clk); chk("oor_ack", 32'(cpu_ack), 1); chk("oor_rd", 32'(mem_rd_en), 0);
        cyc(); cpu_req = 0;
        @(negedge clk); chk("oor_valid", 32'(cpu_valid), 1); chk("oor_data", 32'(cpu_data), 0);
        cyc();
        @(negedge clk); chk("oor_hold", 32'(cpu_data), 0); chk("oor_valid_off", 32'(cpu_valid), 0);

        // Reset right after a video grant drops the pending return
        cyc(); vid_req = 1; vid_addr = 7;
        @(negedge clk); chk("mrst_ack", 32'(vid_ack), 1);
        cyc(); vid_req = 0; rst = 1;
        @(negedge clk); chk("mrst_valid", 32'(vid_valid), 0); chk("mrst_ack0", 32'(vid_ack), 0);
        cyc(); rst = 0;
        @(negedge clk); chk("mrst_valid2", 32'(vid_valid), 0); chk("mrst_conflict", 32'(conflict_cnt), 0);
        chk("mrst_vdata", 32'(vid_data), 0);

        // Long conflict: counter saturates, CPU gets one grant per MAX_WAIT+1 cycles
        cyc(); vid_req = 1; cpu_req = 1; vid_addr = 100; cpu_addr = 200;
        ngrant = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (cpu_ack) ngrant++;
            cyc();
        end
        vid_req = 0; cpu_req = 0;
        @(negedge clk);
        chk("sat_conflict", 32'(conflict_cnt), 32'hFFFF);
        chk("sat_cpu_grants", 32'(ngrant), 14000);

        // Randomized traffic with legal handshakes, abandons and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); va = vid_ack; ca = cpu_ack;
            @(posedge clk); #1;
            if (rst) rst = 0;
            else if ($urandom_range(0, 199) == 0) rst = 1;
            if (!vid_req || va) begin
                vid_req = ($urandom_range(0, 3) != 0); vid_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) vid_req = 0;
            if (!cpu_req || ca) begin
                cpu_req = ($urandom_range(0, 2) == 0); cpu_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) cpu_req = 0;
        end
        cyc(); vid_req = 0; cpu_req = 0; rst = 0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
